// File: rtl/sar_adc_pkg.sv
// Shared types and default parameters for the SAR ADC controller.
package sar_adc_pkg;

  localparam int unsigned N_DEF          = 12;
  localparam int unsigned SAMPLE_CYC_DEF = 2;
  localparam int unsigned SETTLE_CYC_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Larger of two unsigned values, for sizing the shared phase counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Bundle between the SAR controller and the analog front end / downstream checker.
//   start       : conversion request            (front end -> controller)
//   comp_in     : comparator, 1 = Vin >= Vdac   (front end -> controller)
//   sample_hold : track phase of the S/H        (controller -> front end)
//   dac_en      : DAC enable during CONVERT     (controller -> front end)
//   dac_code    : current trial code            (controller -> front end)
//   busy        : conversion in progress        (controller -> system)
//   data_out    : last converted word           (controller -> system)
//   valid       : one-cycle strobe, new data    (controller -> system)
interface sar_adc_ctrl_if #(
  parameter int unsigned N = 12
);
  logic         start;
  logic         comp_in;
  logic         sample_hold;
  logic         dac_en;
  logic [N-1:0] dac_code;
  logic         busy;
  logic [N-1:0] data_out;
  logic         valid;

  // Front end / bench side.
  modport master (
    output start, comp_in,
    input  sample_hold, dac_en, dac_code, busy, data_out, valid
  );

  // Controller side.
  modport slave (
    input  start, comp_in,
    output sample_hold, dac_en, dac_code, busy, data_out, valid
  );
endinterface

// File: rtl/sar_adc_timer.sv
// Loadable down-counter with terminal-count flag, reused for the sample and
// per-bit settle windows.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load (window length minus one)
//   dec        : decrement while nonzero
//   tc_c       : combinational flag, counter is at zero
module sar_adc_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc_c
);

  logic [W-1:0] count;

  // Counter register; saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: samples, then resolves one bit per
// settle window from MSB to LSB against an external comparator, and presents
// the result with a one-cycle valid strobe.
//   clk, rst_n : clock, async active-low reset
//   bus        : sar_adc_ctrl_if slave (start/comp_in in; sample_hold, dac_en,
//                dac_code, busy, data_out, valid out, all registered)
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  sar_adc_ctrl_if.slave       bus
);

  localparam int unsigned CNT_RAW = $clog2(max_u(SAMPLE_CYC, SETTLE_CYC));
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;

  state_t         state;
  logic [IDX_W-1:0] bit_idx;
  logic           sample_hold;
  logic           dac_en;
  logic [N-1:0]   dac_code;
  logic           busy;
  logic [N-1:0]   data_out;
  logic           valid;

  logic           tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic           tmr_dec_c;
  logic           tmr_tc_c;

  logic [N-1:0]   trial_bit_c;
  logic [N-1:0]   decided_c;
  logic [N-1:0]   next_trial_c;

  sar_adc_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .dec      (tmr_dec_c),
    .tc_c     (tmr_tc_c)
  );

  // Timer control: load the window length on each phase/bit entry, else count.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    tmr_dec_c  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(SAMPLE_CYC - 1);
        end
      end
      ST_SAMPLE: begin
        if (tmr_tc_c) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(SETTLE_CYC - 1);
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (tmr_tc_c && (bit_idx != '0)) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = CNT_W'(SETTLE_CYC - 1);
        end else begin
          tmr_dec_c = 1'b1;
        end
      end
      default: begin
        tmr_dec_c = 1'b0;
      end
    endcase
  end

  // Bit decision: drop the trial bit if Vin < Vdac, then arm the next lower bit.
  always_comb begin
    trial_bit_c  = N'(1) << bit_idx;
    decided_c    = bus.comp_in ? dac_code : (dac_code & ~trial_bit_c);
    next_trial_c = decided_c | (trial_bit_c >> 1);
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      sample_hold <= 1'b0;
      dac_en      <= 1'b0;
      dac_code    <= '0;
      busy        <= 1'b0;
      data_out    <= '0;
      valid       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          if (bus.start) begin
            state       <= ST_SAMPLE;
            sample_hold <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (tmr_tc_c) begin
            state       <= ST_CONVERT;
            sample_hold <= 1'b0;
            dac_en      <= 1'b1;
            dac_code    <= N'(1) << (N - 1);
            bit_idx     <= IDX_W'(N - 1);
          end
        end
        ST_CONVERT: begin
          if (tmr_tc_c) begin
            if (bit_idx == '0) begin
              // Final code stays on the DAC through DONE, cleared on exit.
              state    <= ST_DONE;
              dac_en   <= 1'b0;
              dac_code <= decided_c;
              data_out <= decided_c;
              valid    <= 1'b1;
            end else begin
              dac_code <= next_trial_c;
              bit_idx  <= bit_idx - IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          valid    <= 1'b0;
          busy     <= 1'b0;
          dac_code <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sample_hold = sample_hold;
  assign bus.dac_en      = dac_en;
  assign bus.dac_code    = dac_code;
  assign bus.busy        = busy;
  assign bus.data_out    = data_out;
  assign bus.valid       = valid;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: default configuration plus a second
// instance with SAMPLE_CYC=1, SETTLE_CYC=3, each driven by an ideal 3.3 V
// 12-bit DAC/comparator model.
module tb_sar_adc_ctrl;

  logic clk;
  logic rst_n;
  real  vin_a;
  real  vin_b;

  int n_cmp;
  int n_err;

  sar_adc_ctrl_if #(.N(12)) bus_a ();
  sar_adc_ctrl_if #(.N(12)) bus_b ();

  sar_adc_ctrl #(.N(12), .SAMPLE_CYC(2), .SETTLE_CYC(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  sar_adc_ctrl #(.N(12), .SAMPLE_CYC(1), .SETTLE_CYC(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Ideal comparator against the DAC output voltage.
  assign bus_a.comp_in = (vin_a >= 3.3 * real'(bus_a.dac_code) / 4096.0);
  assign bus_b.comp_in = (vin_b >= 3.3 * real'(bus_b.dac_code) / 4096.0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One conversion on instance A; edges counted from the start-accept edge E0.
  task automatic run_a(input string tag, input real vin, input logic [11:0] exp_data,
                       input bit hold_start, input bit chk_trace,
                       input logic [11:0] exp_trace [6]);
    int first_valid;
    int n_valid;
    int idx;
    logic [11:0] trace [12];
    vin_a = vin;
    first_valid = 0;
    n_valid = 0;
    idx = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        check_eq({tag, " sh_e1"}, 32'(bus_a.sample_hold), 32'd1);
        check_eq({tag, " den_e1"}, 32'(bus_a.dac_en), 32'd0);
      end
      if (i == 2) begin
        check_eq({tag, " sh_e2"}, 32'(bus_a.sample_hold), 32'd0);
        check_eq({tag, " den_e2"}, 32'(bus_a.dac_en), 32'd1);
      end
      if (i >= 2 && (i % 2) == 0 && idx < 12) begin
        trace[idx] = bus_a.dac_code;
        idx++;
      end
      if (bus_a.valid) begin
        n_valid++;
        if (first_valid == 0) first_valid = i;
      end
      if (hold_start && i == 4)  bus_a.start = 1'b1;
      if (hold_start && i == 26) bus_a.start = 1'b0;
    end
    check_eq({tag, " valid_edge"}, 32'(first_valid), 32'd26);
    check_eq({tag, " valid_count"}, 32'(n_valid), 32'd1);
    check_eq({tag, " data"}, 32'(bus_a.data_out), 32'(exp_data));
    check_eq({tag, " busy_end"}, 32'(bus_a.busy), 32'd0);
    check_eq({tag, " code_end"}, 32'(bus_a.dac_code), 32'd0);
    check_eq({tag, " trace0"}, 32'(trace[0]), 32'h800);
    if (chk_trace) begin
      for (int j = 1; j < 6; j++)
        check_eq($sformatf("%s trace%0d", tag, j), 32'(trace[j]), 32'(exp_trace[j]));
    end
  endtask

  logic [11:0] no_trace [6];
  logic [11:0] tr_1v0 [6];

  initial begin
    int n_valid;
    int first_valid;
    n_cmp = 0;
    n_err = 0;
    vin_a = 0.0;
    vin_b = 0.0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    no_trace = '{default: 12'h000};
    tr_1v0 = '{12'h800, 12'h400, 12'h600, 12'h500, 12'h480, 12'h4C0};
    rst_n = 1'b0;

    #1;
    check_eq("rst sample_hold", 32'(bus_a.sample_hold), 32'd0);
    check_eq("rst dac_en", 32'(bus_a.dac_en), 32'd0);
    check_eq("rst dac_code", 32'(bus_a.dac_code), 32'd0);
    check_eq("rst busy", 32'(bus_a.busy), 32'd0);
    check_eq("rst data_out", 32'(bus_a.data_out), 32'd0);
    check_eq("rst valid", 32'(bus_a.valid), 32'd0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_a("v1p65", 1.65, 12'h800, 1'b0, 1'b0, no_trace);
    run_a("v0p0",  0.0,  12'h000, 1'b0, 1'b0, no_trace);
    run_a("v3p3",  3.3,  12'hFFF, 1'b0, 1'b0, no_trace);
    run_a("v1p0",  1.0,  12'h4D9, 1'b0, 1'b1, tr_1v0);
    run_a("hold",  3.3,  12'hFFF, 1'b1, 1'b0, no_trace);
    run_a("after_hold", 1.0, 12'h4D9, 1'b0, 1'b0, no_trace);

    // Reset in the middle of a conversion.
    vin_a = 2.5;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort sample_hold", 32'(bus_a.sample_hold), 32'd0);
    check_eq("abort dac_en", 32'(bus_a.dac_en), 32'd0);
    check_eq("abort dac_code", 32'(bus_a.dac_code), 32'd0);
    check_eq("abort busy", 32'(bus_a.busy), 32'd0);
    check_eq("abort data_out", 32'(bus_a.data_out), 32'd0);
    check_eq("abort valid", 32'(bus_a.valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus_a.valid) n_valid++;
    end
    check_eq("abort no_valid", 32'(n_valid), 32'd0);
    check_eq("abort idle_busy", 32'(bus_a.busy), 32'd0);
    run_a("post_rst", 1.0, 12'h4D9, 1'b0, 1'b0, no_trace);

    // Second configuration: SAMPLE_CYC=1, SETTLE_CYC=3.
    vin_b = 2.5;
    n_valid = 0;
    first_valid = 0;
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) check_eq("b code_e1", 32'(bus_b.dac_code), 32'h800);
      if (bus_b.valid) begin
        n_valid++;
        if (first_valid == 0) first_valid = i;
      end
    end
    check_eq("b valid_edge", 32'(first_valid), 32'd37);
    check_eq("b valid_count", 32'(n_valid), 32'd1);
    check_eq("b data", 32'(bus_b.data_out), 32'hC1F);
    check_eq("b busy_end", 32'(bus_b.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Synthesizable successive-approximation ADC controller for the sine-wave project: the capture side of the 12-bit DAC path. It drives a trial code into the bench DAC model (Vref = 3.3), reads back an external comparator result, and resolves one bit per step from MSB to LSB. It then presents the converted word with a one-cycle valid strobe. It sits between the analog front end (sample/hold plus comparator) and the digital sine checker.

## Interface
- N, 12, resolution in bits; dac_code and data_out width
- SAMPLE_CYC, 2, cycles sample_hold stays high before conversion (≥1)
- SETTLE_CYC, 2, cycles each trial code is held before comp_in is sampled (≥1)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request conversion; accepted only in IDLE
- comp_in  in  1  comparator: 1 = Vin ≥ Vdac(dac_code)
- sample_hold  out  1  high while front end tracks Vin
- dac_en  out  1  DAC enable; high during CONVERT only
- dac_code  out  N  current trial code to DAC
- busy  out  1  high in SAMPLE, CONVERT, DONE
- data_out  out  N  last converted code, held until next DONE
- valid  out  1  one-cycle strobe, data_out new

## Operation
- States: IDLE, SAMPLE, CONVERT, DONE (enum in package).
- IDLE: start=1 at an edge → SAMPLE; sample_hold=1, settle counter cleared.
- SAMPLE: counts SAMPLE_CYC cycles → CONVERT; bit index k=N-1; dac_code = 1<<(N-1); dac_en=1.
- CONVERT: each bit k holds dac_code for SETTLE_CYC cycles; on last cycle's edge comp_in sampled:
  - comp_in=0 → clear bit k; comp_in=1 → keep.
  - k>0 → set bit k-1, k decrements, counter restarts.
  - k=0 → final code registered to data_out, → DONE.
- DONE: valid=1 for exactly one cycle, dac_en=0, → IDLE unconditionally.
- start while busy (incl. DONE) ignored, not queued; start held high in IDLE retriggers each time IDLE is re-entered.
- dac_code returns to 0 on DONE exit; data_out unchanged until next DONE.
- Bits resolved never change after decision; bits below k are 0 during trial.
- Counters: settle counter width $clog2(max(SAMPLE_CYC,SETTLE_CYC)); bit index $clog2(N).

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE, sample_hold=0, dac_en=0, dac_code=0, busy=0, data_out=0, valid=0, counters=0.
- Reset mid-conversion aborts immediately; no valid issued; data_out cleared to 0.
- Start accepted at edge E0; sample_hold high after E0 through E_SAMPLE_CYC.
- Bit decision for bit N-1-m at edge E_(SAMPLE_CYC+(m+1)*SETTLE_CYC).
- data_out/valid update at edge E_(SAMPLE_CYC+N*SETTLE_CYC); valid low again after next edge.
- Earliest next start accepted at edge E_(SAMPLE_CYC+N*SETTLE_CYC+2) (first IDLE cycle).
- comp_in assumed stable for the full settle window; sampled once per bit, no filtering.

## Structure
- Package sar_adc_pkg: state_t enum, default N, SAMPLE_CYC, SETTLE_CYC constants.
- Sub-module sar_adc_timer: loadable down-counter with terminal-count flag, shared by SAMPLE and CONVERT phases.
- Bench: comparator model computes comp_in = (Vin ≥ 3.3*dac_code/2^N) from the DAC output.

## Test plan
- Defaults, Vin=1.65 V, start pulse → valid at E26, data_out=0x800, sequence of dac_code starts 0x800.
- Vin=0.0 V → data_out=0x000; Vin=3.3 V → data_out=0xFFF; each valid exactly one cycle.
- Vin=1.0 V → data_out=0x4D9 (1241); dac_code trace 0x800,0x400,0x600,0x500,0x480,0x4C0,...
- start re-pulsed at E5 and held in DONE → ignored; only one valid; next conversion starts from IDLE.
- rst_n low at E10 of conversion → all outputs 0 immediately; no valid; fresh start converts correctly.
- SAMPLE_CYC=1, SETTLE_CYC=3, Vin=2.5 V → valid at E37, data_out=0xC1F (3103).
